// File: rtl/hadd_resp_checker.sv
// Response checker for the half-adder bench: golden compare, per-output mismatch stats, pass/done.
// Optional macro HADD_CHK_PIPE_EN adds one input register stage ahead of the comparison.
module hadd_resp_checker #(
    parameter int CNT_W       = 16,
    parameter int NUM_SAMPLES = 200
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic             sample_valid,
    input  logic             a,
    input  logic             b,
    input  logic             sum_dut,
    input  logic             cout_dut,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] samples,
    output logic [CNT_W-1:0] errors,
    output logic [CNT_W-1:0] errors_sum,
    output logic [CNT_W-1:0] errors_cout,
    output logic [CNT_W-1:0] first_err_sum,
    output logic [CNT_W-1:0] first_err_cout
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] NUM_C   = CNT_W'(NUM_SAMPLES);

    state_t state, state_next;
    logic   clear, count;

    logic cmp_valid, cmp_a, cmp_b, cmp_sum, cmp_cout, stop_eff;
    logic mis_s, mis_c;

`ifdef HADD_CHK_PIPE_EN
    logic valid_q, a_q, b_q, sum_q, cout_q, stop_q;

    // start flushes the stage so a sample or stop from before the restart never lands in the new run
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            sum_q   <= 1'b0;
            cout_q  <= 1'b0;
            stop_q  <= 1'b0;
        end else begin
            valid_q <= sample_valid & ~start;
            a_q     <= a;
            b_q     <= b;
            sum_q   <= sum_dut;
            cout_q  <= cout_dut;
            stop_q  <= stop & ~start;
        end
    end

    assign cmp_valid = valid_q;
    assign cmp_a     = a_q;
    assign cmp_b     = b_q;
    assign cmp_sum   = sum_q;
    assign cmp_cout  = cout_q;
    assign stop_eff  = stop_q;
`else
    assign cmp_valid = sample_valid;
    assign cmp_a     = a;
    assign cmp_b     = b;
    assign cmp_sum   = sum_dut;
    assign cmp_cout  = cout_dut;
    assign stop_eff  = stop;
`endif

    assign mis_s = (cmp_a ^ cmp_b) ^ cmp_sum;
    assign mis_c = (cmp_a & cmp_b) ^ cmp_cout;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // NOTE: every output of this block gets a default first, otherwise missing branches infer latches.
    always_comb begin
        state_next = state;
        clear      = 1'b0;
        count      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                    clear      = 1'b1;
                end
            end
            RUN: begin
                if (start) begin
                    clear = 1'b1;
                end else begin
                    if (cmp_valid) begin
                        count = 1'b1;
                        if (samples == NUM_C - CNT_W'(1)) state_next = DONE;
                    end
                    if (stop_eff) state_next = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    state_next = RUN;
                    clear      = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // First-error indices latch only while their error count is still zero, so once per run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            samples        <= '0;
            errors         <= '0;
            errors_sum     <= '0;
            errors_cout    <= '0;
            first_err_sum  <= '0;
            first_err_cout <= '0;
        end else if (clear) begin
            samples        <= '0;
            errors         <= '0;
            errors_sum     <= '0;
            errors_cout    <= '0;
            first_err_sum  <= '0;
            first_err_cout <= '0;
        end else if (count) begin
            samples <= sat_inc(samples);
            if (mis_s | mis_c) errors <= sat_inc(errors);
            if (mis_s) begin
                errors_sum <= sat_inc(errors_sum);
                if (errors_sum == '0) first_err_sum <= samples;
            end
            if (mis_c) begin
                errors_cout <= sat_inc(errors_cout);
                if (errors_cout == '0) first_err_cout <= samples;
            end
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);
    assign pass = done && (errors == '0) && (samples == NUM_C);

endmodule
